// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: the NOP encoding shown when the queue is empty
// and the layout of one fetch-queue entry.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One buffered fetch: PC, precomputed PC+4 and the instruction word.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH words, one synchronous write port,
// one asynchronous read port. Contents are never cleared; the owner decides
// which words are visible.
module fetch_queue_mem
    import riscv_pkg::*;
#(
    parameter int WIDTH = 3 * XLEN,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port: capture the pushed entry at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode queue. Buffers PC/instruction pairs in push order, with
// PC+4 computed once on entry. Occupancy alone decides what is visible, so
// flush and reset only clear pointers and count.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int DEPTH   = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               Flush,
    input  logic               InValid,
    output logic               InReady,
    input  logic [D_WIDTH-1:0] InPC,
    input  logic [D_WIDTH-1:0] InInstr,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [D_WIDTH-1:0] OutPC,
    output logic [D_WIDTH-1:0] OutPCPlus4,
    output logic [D_WIDTH-1:0] OutInstr,
    output logic [CNT_W-1:0]   Count
);

    // Entry word layout matches fetch_entry_t: {pc, pc_plus4, instr}.
    localparam int ENTRY_W = 3 * D_WIDTH;

    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               we_s;
    logic [ENTRY_W-1:0] wdata_s;
    logic [ENTRY_W-1:0] rdata_s;

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == CNT_W'(0));
    // Readiness depends only on occupancy: a full queue refuses a push even
    // when the head is being popped in the same cycle.
    assign push_s  = InValid && !full_s;
    assign pop_s   = OutReady && !empty_s;
    assign we_s    = push_s && !Flush && !rst;
    assign wdata_s = {InPC, InPC + D_WIDTH'(4), InInstr};

    fetch_queue_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (CLK),
        .we    (we_s),
        .waddr (wr_ptr_r),
        .wdata (wdata_s),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    // Pointer and occupancy update: reset, then flush, then push/pop.
    always_ff @(posedge CLK) begin
        if (rst || Flush) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation: stored entry when occupied, zeros and NOP otherwise.
    always_comb begin
        OutValid   = 1'b0;
        OutPC      = '0;
        OutPCPlus4 = '0;
        OutInstr   = D_WIDTH'(NOP_INSTR);
        if (!empty_s) begin
            OutValid   = 1'b1;
            OutPC      = rdata_s[3*D_WIDTH-1 -: D_WIDTH];
            OutPCPlus4 = rdata_s[2*D_WIDTH-1 -: D_WIDTH];
            OutInstr   = rdata_s[D_WIDTH-1 -: D_WIDTH];
        end else begin
            OutValid   = 1'b0;
        end
    end

    assign InReady = !full_s;
    assign Count   = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written
// wrap/reset sequences, then random traffic against a queue-based model.
module tb_fetch_queue;
    import riscv_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          rst;
    logic          Flush;
    logic          InValid;
    logic          InReady;
    logic [DW-1:0] InPC;
    logic [DW-1:0] InInstr;
    logic          OutValid;
    logic          OutReady;
    logic [DW-1:0] OutPC;
    logic [DW-1:0] OutPCPlus4;
    logic [DW-1:0] OutInstr;
    logic [CW-1:0] Count;

    int errors = 0;
    int checks = 0;

    fetch_queue #(.D_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .Flush      (Flush),
        .InValid    (InValid),
        .InReady    (InReady),
        .InPC       (InPC),
        .InInstr    (InInstr),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutPC      (OutPC),
        .OutPCPlus4 (OutPCPlus4),
        .OutInstr   (OutInstr),
        .Count      (Count)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: a plain FIFO of entries.
    fetch_entry_t model_q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA500_0000 ^ pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic f, input logic iv,
                              input logic ordy, input logic [31:0] pc, input logic [31:0] ins);
        fetch_entry_t e;
        bit do_pop;
        bit do_push;
        if (r || f) begin
            model_q.delete();
        end else begin
            do_pop  = (model_q.size() > 0) && ordy;
            do_push = iv && (model_q.size() < DEPTH);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.pc       = pc;
                e.pc_plus4 = pc + 32'd4;
                e.instr    = ins;
                model_q.push_back(e);
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, sample after the edge.
    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic ordy, input logic [31:0] pc);
        rst      = r;
        Flush    = f;
        InValid  = iv;
        OutReady = ordy;
        InPC     = pc;
        InInstr  = instr_of(pc);
        model_edge(r, f, iv, ordy, pc, instr_of(pc));
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_model(input string tag);
        if (model_q.size() == 0) begin
            chk({tag, ".ovalid"}, 32'(OutValid), 32'd0);
            chk({tag, ".opc"},    OutPC,         32'd0);
            chk({tag, ".opc4"},   OutPCPlus4,    32'd0);
            chk({tag, ".oinstr"}, OutInstr,      NOP_INSTR);
        end else begin
            chk({tag, ".ovalid"}, 32'(OutValid), 32'd1);
            chk({tag, ".opc"},    OutPC,         model_q[0].pc);
            chk({tag, ".opc4"},   OutPCPlus4,    model_q[0].pc_plus4);
            chk({tag, ".oinstr"}, OutInstr,      model_q[0].instr);
        end
        chk({tag, ".count"},  32'(Count),   32'(model_q.size()));
        chk({tag, ".iready"}, 32'(InReady), 32'(model_q.size() != DEPTH));
    endtask

    typedef struct {
        logic        r, f, iv, ordy;
        logic [31:0] pc;
        int          cnt;
        logic [31:0] head;   // expected head PC when cnt > 0
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [31:0] pc, input int cnt, input logic [31:0] head);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.ordy = ordy; v.pc = pc; v.cnt = cnt; v.head = head;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        InPC = 32'd0; InInstr = 32'd0;

        // Reset and idle
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        0, 32'h0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        0, 32'h0);
        // Fill with decode stalled; fifth push refused
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1, 32'h0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h4,        2, 32'h0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h8,        3, 32'h0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'hC,        4, 32'h0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h10,       4, 32'h0);
        // Drain in order
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        3, 32'h4);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        2, 32'h8);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        1, 32'hC);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        0, 32'h0);
        // PC+4 wraps around the top of the address space
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        0, 32'h0);
        // Three entries, then flush with a push and pop requested
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h20,       1, 32'h20);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h24,       2, 32'h20);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h28,       3, 32'h20);
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'h100,      0, 32'h0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        0, 32'h0);
        // Fill, then reset while full with decode ready
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h40,       1, 32'h40);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h44,       2, 32'h40);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h48,       3, 32'h40);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h4C,       4, 32'h40);
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'h200,      0, 32'h0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].ordy, vecs[i].pc);
            chk($sformatf("vec%0d.count", i),  32'(Count),   32'(vecs[i].cnt));
            chk($sformatf("vec%0d.iready", i), 32'(InReady), 32'(vecs[i].cnt != DEPTH));
            chk($sformatf("vec%0d.ovalid", i), 32'(OutValid), 32'(vecs[i].cnt != 0));
            if (vecs[i].cnt != 0) begin
                chk($sformatf("vec%0d.opc", i),    OutPC,      vecs[i].head);
                chk($sformatf("vec%0d.opc4", i),   OutPCPlus4, vecs[i].head + 32'd4);
                chk($sformatf("vec%0d.oinstr", i), OutInstr,   instr_of(vecs[i].head));
            end else begin
                chk($sformatf("vec%0d.opc", i),    OutPC,      32'd0);
                chk($sformatf("vec%0d.opc4", i),   OutPCPlus4, 32'd0);
                chk($sformatf("vec%0d.oinstr", i), OutInstr,   32'h0000_0013);
            end
        end

        // Steady push+pop from two entries; pointers wrap several times
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h300);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h304);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h308 + 32'(4 * i));
            chk($sformatf("stream%0d.count", i), 32'(Count), 32'd2);
            chk($sformatf("stream%0d.opc", i),   OutPC,      32'h300 + 32'(4 * (i + 1)));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("stream.tail0", OutPC, 32'h32C);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("stream.empty", 32'(OutValid), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                  {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            chk_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter D_WIDTH, default 32, datapath width of PC and instruction.
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, at least 2.
REQ-003 CLK  input  1  the block's single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 Flush  input  1  redirect (branch/jump taken); discard all entries.
REQ-006 InValid  input  1  fetch stage presents a valid PC/instruction pair.
REQ-007 InReady  output  1  queue can accept a push this cycle.
REQ-008 InPC  input  D_WIDTH  PC of the fetched instruction.
REQ-009 InInstr  input  D_WIDTH  instruction word read at InPC.
REQ-010 OutValid  output  1  head entry valid toward decode.
REQ-011 OutReady  input  1  decode accepts the head entry this cycle.
REQ-012 OutPC  output  D_WIDTH  PC of head entry.
REQ-013 OutPCPlus4  output  D_WIDTH  head PC + 4.
REQ-014 OutInstr  output  D_WIDTH  instruction of head entry.
REQ-015 Count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Push SHALL occur on a rising edge when InValid && InReady && !Flush && !rst.
REQ-017 Pop SHALL occur on a rising edge when OutValid && OutReady && !Flush && !rst.
REQ-018 InReady SHALL equal (Count != DEPTH), independent of OutReady; no push when full, even if a pop occurs in the same cycle.
REQ-019 OutValid SHALL equal (Count != 0); no same-cycle bypass from input to output; minimum latency is one cycle.
REQ-020 OutPCPlus4 SHALL be computed at push time as InPC + 4, modulo 2^D_WIDTH, and stored with the entry.
REQ-021 When OutValid = 0, OutPC = 0, OutPCPlus4 = 0, OutInstr = 32'h00000013 (NOP).
REQ-022 Simultaneous push and pop (not full, not empty) SHALL leave Count unchanged and advance both pointers.
REQ-023 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-024 Entries SHALL be delivered in push order; none dropped, none duplicated.
REQ-025 Flush SHALL set Count and both pointers to 0 on the next edge; any push or pop requested in the flush cycle is ignored.
REQ-026 Storage contents need not be cleared by Flush or rst; visibility is governed by Count only.
REQ-027 Priority per edge: rst > Flush > push/pop.

Reset
REQ-028 On a rising edge with rst = 1: Count = 0, pointers = 0, so OutValid = 0, InReady = 1, outputs per REQ-021.
REQ-029 Reset mid-operation SHALL discard all entries identically to Flush, regardless of InValid/OutReady.

Structure
REQ-030 Shared package riscv_pkg SHALL hold the NOP_INSTR constant (32'h00000013) and the fetch-entry struct {pc, pc_plus4, instr}.
REQ-031 One sub-module, fetch_queue_mem: DEPTH x entry register array, one write port, one asynchronous read port; pointer/count control stays in fetch_queue.

Verification
REQ-032 Reset then idle -> Count = 0, OutValid = 0, InReady = 1, OutInstr = 32'h00000013.
REQ-033 Push PC 0x00000000, 0x4, 0x8, 0xC with OutReady = 0 -> Count = 4, InReady = 0; 5th push of 0x10 is refused; then OutReady = 1 drains 0x0, 0x4, 0x8, 0xC in order with OutPCPlus4 = 0x4, 0x8, 0xC, 0x10.
REQ-034 Continuous push and pop for 10 cycles from Count = 2 -> Count stays 2 and pointers wrap past 3 to 0 without data loss.
REQ-035 Queue holds 3 entries; Flush = 1 together with InValid = 1 (PC 0x100) -> next cycle Count = 0, OutValid = 0; PC 0x100 never appears at the output.
REQ-036 Push InPC = 0xFFFFFFFC -> OutPCPlus4 = 0x00000000.
REQ-037 rst = 1 asserted while full and OutReady = 1 -> next cycle Count = 0, InReady = 1, no pop observed.
